// File: rtl/tile_fetcher_if.sv
// Memory read port and tile word stream between tile_fetcher, tile memory
// and the pixel quadrupler.
interface tile_fetcher_if #(
   parameter int CORDW = 11,
   parameter int ADDRW = 16
);
   logic             mem_req;
   logic [ADDRW-1:0] mem_addr;
   logic             mem_ack;
   logic [31:0]      mem_rdata;
   logic             tile_valid;
   logic             tile_ready;
   logic [31:0]      tile_pixels;
   logic [3:0]       tile_valid_mask;
   logic [CORDW-1:0] tile_x;

   modport master (
      output mem_req, mem_addr,
      input  mem_ack, mem_rdata,
      output tile_valid, tile_pixels, tile_valid_mask, tile_x,
      input  tile_ready
   );

   modport slave (
      input  mem_req, mem_addr,
      output mem_ack, mem_rdata,
      input  tile_valid, tile_pixels, tile_valid_mask, tile_x,
      output tile_ready
   );
endinterface

// File: rtl/tile_fetcher.sv
// Per-line tile word sequencer: map lookup, tile row fetch, then one
// {pixels, mask, x} word per tile under valid/ready.
module tile_fetcher #(
   parameter int CORDW    = 11,
   parameter int ADDRW    = 16,
   parameter int LINE_W   = 640,
   parameter int TILES    = 41,
   parameter int MAP_LOG2 = 6
) (
   input  logic             clk_draw,
   input  logic             rst_draw,
   input  logic             line_start,
   input  logic [CORDW-1:0] line_y,
   input  logic [CORDW-1:0] scroll_x,
   input  logic [ADDRW-1:0] map_base,
   input  logic [ADDRW-1:0] gfx_base,
   tile_fetcher_if.master   bus,
   output logic             line_done
);
   localparam int IW = $clog2(TILES);

   typedef enum logic [1:0] {IDLE, MAP_REQ, GFX_REQ, EMIT} state_t;

   state_t           state, state_nxt;
   logic [IW-1:0]    i_q, i_nxt;
   logic [CORDW-1:0] ly_q, ly_nxt;
   logic [CORDW-1:0] sx_q, sx_nxt;
   logic             req_q, req_nxt;
   logic [ADDRW-1:0] addr_q, addr_nxt;
   logic             valid_q, valid_nxt;
   logic [31:0]      pix_q, pix_nxt;
   logic [3:0]       mask_q, mask_nxt;
   logic [CORDW-1:0] tx_q, tx_nxt;
   logic             done_q, done_nxt;
   logic             unused_bits;

   // Map row/col wrap at the map size before the base offset is applied.
   function automatic logic [ADDRW-1:0] map_addr(
      input logic [ADDRW-1:0]    base,
      input logic [MAP_LOG2-1:0] row,
      input logic [MAP_LOG2-1:0] col0,
      input logic [IW-1:0]       k
   );
      logic [MAP_LOG2-1:0] col;
      col = col0 + MAP_LOG2'(k);
      return base + ADDRW'({row, col});
   endfunction

   function automatic logic [3:0] lane_mask(input logic [IW-1:0] k, input logic [3:0] fine);
      int pos;
      lane_mask = '0;
      for (int unsigned j = 0; j < 4; j++) begin
         pos = 16 * int'(k) + 4 * int'(j) - int'(fine);
         lane_mask[j[1:0]] = (pos >= 0) && (pos < LINE_W);
      end
   endfunction

   always_ff @(posedge clk_draw) begin
      if (!rst_draw) begin
         state   <= IDLE;
         i_q     <= '0;
         ly_q    <= '0;
         sx_q    <= '0;
         req_q   <= 1'b0;
         addr_q  <= '0;
         valid_q <= 1'b0;
         pix_q   <= '0;
         mask_q  <= '0;
         tx_q    <= '0;
         done_q  <= 1'b0;
      end else begin
         state   <= state_nxt;
         i_q     <= i_nxt;
         ly_q    <= ly_nxt;
         sx_q    <= sx_nxt;
         req_q   <= req_nxt;
         addr_q  <= addr_nxt;
         valid_q <= valid_nxt;
         pix_q   <= pix_nxt;
         mask_q  <= mask_nxt;
         tx_q    <= tx_nxt;
         done_q  <= done_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      i_nxt     = i_q;
      ly_nxt    = ly_q;
      sx_nxt    = sx_q;
      req_nxt   = req_q;
      addr_nxt  = addr_q;
      valid_nxt = valid_q;
      pix_nxt   = pix_q;
      mask_nxt  = mask_q;
      tx_nxt    = tx_q;
      done_nxt  = 1'b0;
      // A line start restarts from any state; a coincident ack is ignored.
      if (line_start) begin
         state_nxt = MAP_REQ;
         i_nxt     = '0;
         ly_nxt    = line_y;
         sx_nxt    = scroll_x;
         req_nxt   = 1'b1;
         addr_nxt  = map_addr(map_base, line_y[4 +: MAP_LOG2], scroll_x[4 +: MAP_LOG2], '0);
         valid_nxt = 1'b0;
      end else begin
         unique case (state)
            IDLE: state_nxt = IDLE;
            MAP_REQ: begin
               if (bus.mem_ack) begin
                  state_nxt = GFX_REQ;
                  addr_nxt  = gfx_base + ADDRW'({bus.mem_rdata[7:0], ly_q[3:2]});
               end
            end
            GFX_REQ: begin
               if (bus.mem_ack) begin
                  state_nxt = EMIT;
                  req_nxt   = 1'b0;
                  pix_nxt   = bus.mem_rdata;
                  valid_nxt = 1'b1;
                  tx_nxt    = CORDW'({i_q, 4'b0000}) - CORDW'(sx_q[3:0]);
                  mask_nxt  = lane_mask(i_q, sx_q[3:0]);
               end
            end
            EMIT: begin
               if (bus.tile_ready) begin
                  valid_nxt = 1'b0;
                  if (i_q == IW'(TILES - 1)) begin
                     state_nxt = IDLE;
                     done_nxt  = 1'b1;
                  end else begin
                     state_nxt = MAP_REQ;
                     i_nxt     = i_q + IW'(1);
                     req_nxt   = 1'b1;
                     addr_nxt  = map_addr(map_base, ly_q[4 +: MAP_LOG2], sx_q[4 +: MAP_LOG2],
                                          i_q + IW'(1));
                  end
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   assign bus.mem_req         = req_q;
   assign bus.mem_addr        = addr_q;
   assign bus.tile_valid      = valid_q;
   assign bus.tile_pixels     = pix_q;
   assign bus.tile_valid_mask = mask_q;
   assign bus.tile_x          = tx_q;
   assign line_done           = done_q;
   assign unused_bits         = ^{ly_q, sx_q};
endmodule

// File: tb/tb_tile_fetcher.sv
// Directed bench for tile_fetcher: memory responder, stalling consumer and a
// per-line word model checked every cycle.
module tb_tile_fetcher;
   localparam int CORDW = 11;
   localparam int ADDRW = 16;
   localparam int NT    = 41;

   logic             clk_draw = 1'b0;
   logic             rst_draw;
   logic             line_start;
   logic [CORDW-1:0] line_y;
   logic [CORDW-1:0] scroll_x;
   logic [ADDRW-1:0] map_base;
   logic [ADDRW-1:0] gfx_base;
   logic             line_done;

   tile_fetcher_if #(.CORDW(CORDW), .ADDRW(ADDRW)) bus ();

   tile_fetcher #(.CORDW(CORDW), .ADDRW(ADDRW), .LINE_W(640), .TILES(NT), .MAP_LOG2(6)) dut (
      .clk_draw  (clk_draw),
      .rst_draw  (rst_draw),
      .line_start(line_start),
      .line_y    (line_y),
      .scroll_x  (scroll_x),
      .map_base  (map_base),
      .gfx_base  (gfx_base),
      .bus       (bus),
      .line_done (line_done)
   );

   always #5 clk_draw = ~clk_draw;

   logic [31:0] mem [0:65535];
   int nchecks = 0;
   int nerr    = 0;

   int          ack_delay  = 0;
   int          wcnt       = 0;
   logic        force_ack  = 1'b0;
   logic [31:0] force_data = 32'hDEAD_BEEF;
   int          stall_n    = 0;
   int          vcnt       = 0;
   int          hold_at    = -1;
   int          test_id    = 0;

   int   ei = 0, req_k = 0, cyc = 0;
   logic active = 1'b0;
   int   e_maddr [NT], e_gaddr [NT], e_tx [NT];
   logic [31:0] e_pix [NT];
   logic [3:0]  e_mask [NT];
   int   obs_maddr [NT], obs_gaddr [NT], obs_tx [NT];
   logic [31:0] obs_pix [NT];
   logic [3:0]  obs_mask [NT];
   logic        prev_req = 1'b0, prev_ack = 1'b0, prev_ls = 1'b0, prev_rst_low = 1'b0;
   logic [ADDRW-1:0] prev_addr = '0;

   task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
      nchecks++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Memory: zero-wait when ack_delay is 0, otherwise ack after ack_delay idle cycles.
   always @(negedge clk_draw) begin
      #1;
      if (force_ack) begin
         bus.mem_ack   = 1'b1;
         bus.mem_rdata = force_data;
         wcnt          = 0;
      end else if (bus.mem_req) begin
         if (wcnt >= ack_delay) begin
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = mem[bus.mem_addr];
            wcnt          = 0;
         end else begin
            bus.mem_ack = 1'b0;
            wcnt++;
         end
      end else begin
         bus.mem_ack = 1'b0;
         wcnt        = 0;
      end
   end

   // Consumer: holds ready low for stall_n valid cycles, never accepts word hold_at.
   always @(negedge clk_draw) begin
      #1;
      if (bus.tile_valid) begin
         bus.tile_ready = (vcnt >= stall_n) && (ei != hold_at);
         vcnt++;
      end else begin
         bus.tile_ready = 1'b0;
         vcnt           = 0;
      end
   end

   task automatic build_model();
      int fine, row, col, ma, idx, ga, p;
      logic [3:0] m;
      fine = int'(scroll_x[3:0]);
      row  = (int'(line_y) / 16) % 64;
      for (int k = 0; k < NT; k++) begin
         col = (int'(scroll_x) / 16 + k) % 64;
         ma  = (int'(map_base) + row * 64 + col) % 65536;
         idx = int'(mem[ma] & 32'hFF);
         ga  = (int'(gfx_base) + idx * 4 + (int'(line_y) / 4) % 4) % 65536;
         m   = '0;
         for (int j = 0; j < 4; j++) begin
            p = 16 * k + 4 * j - fine;
            if (p >= 0 && p < 640) m = m | (4'b0001 << j);
         end
         e_maddr[k] = ma;
         e_gaddr[k] = ga;
         e_pix[k]   = mem[ga];
         e_tx[k]    = (16 * k - fine + 2048) % 2048;
         e_mask[k]  = m;
      end
   endtask

   task automatic literal_checks();
      case (test_id)
         1: begin
            chk("t1_maddr5", 48'(obs_maddr[5]), 48'h105);
            chk("t1_gaddr5", 48'(obs_gaddr[5]), 48'h814);
            chk("t1_pix5",   48'(obs_pix[5]),   48'h14);
            chk("t1_tx5",    48'(obs_tx[5]),    48'd80);
            chk("t1_mask39", 48'(obs_mask[39]), 48'hF);
            chk("t1_maddr40", 48'(obs_maddr[40]), 48'h128);
            chk("t1_gaddr40", 48'(obs_gaddr[40]), 48'h8A0);
            chk("t1_tx40",   48'(obs_tx[40]),   48'd640);
            chk("t1_mask40", 48'(obs_mask[40]), 48'h0);
         end
         2: begin
            chk("t2_maddr0", 48'(obs_maddr[0]), 48'h181);
            chk("t2_gaddr0", 48'(obs_gaddr[0]), 48'hA05);
            chk("t2_pix0",   48'(obs_pix[0]),   48'h205);
            chk("t2_tx0",    48'(obs_tx[0]),    48'h7FA);
            chk("t2_mask0",  48'(obs_mask[0]),  48'b1100);
            chk("t2_maddr40", 48'(obs_maddr[40]), 48'h1A9);
            chk("t2_tx40",   48'(obs_tx[40]),   48'd634);
            chk("t2_mask40", 48'(obs_mask[40]), 48'b0011);
         end
         3: begin
            chk("t3_maddr0", 48'(obs_maddr[0]), 48'h13F);
            chk("t3_maddr1", 48'(obs_maddr[1]), 48'h100);
         end
         4: begin
            chk("t4_tx0",    48'(obs_tx[0]),    48'h7FB);
            chk("t4_mask0",  48'(obs_mask[0]),  48'b1100);
            chk("t4_tx1",    48'(obs_tx[1]),    48'd11);
            chk("t4_mask40", 48'(obs_mask[40]), 48'b0011);
         end
         5: begin
            chk("t5_maddr0", 48'(obs_maddr[0]), 48'h240);
            chk("t5_gaddr0", 48'(obs_gaddr[0]), 48'h901);
         end
         7: begin
            chk("t7_maddr0", 48'(obs_maddr[0]), 48'h1C2);
            chk("t7_tx0",    48'(obs_tx[0]),    48'h0);
         end
         default: ;
      endcase
   endtask

   // Compare process: runs after responder and consumer have settled.
   always @(negedge clk_draw) begin
      #2;
      if (!rst_draw) begin
         active       = 1'b0;
         prev_rst_low = 1'b1;
      end else begin
         if (prev_rst_low) begin
            chk("rst_mem_req",  48'(bus.mem_req),         48'h0);
            chk("rst_mem_addr", 48'(bus.mem_addr),        48'h0);
            chk("rst_valid",    48'(bus.tile_valid),      48'h0);
            chk("rst_pixels",   48'(bus.tile_pixels),     48'h0);
            chk("rst_mask",     48'(bus.tile_valid_mask), 48'h0);
            chk("rst_tile_x",   48'(bus.tile_x),          48'h0);
            chk("rst_done",     48'(line_done),           48'h0);
         end
         if (prev_ls) begin
            chk("start_req",   48'(bus.mem_req),    48'h1);
            chk("start_valid", 48'(bus.tile_valid), 48'h0);
         end else if (!active) begin
            chk("idle_req",   48'(bus.mem_req),    48'h0);
            chk("idle_valid", 48'(bus.tile_valid), 48'h0);
         end
         if (active && !line_start) begin
            cyc++;
            if (bus.mem_req && bus.mem_ack) begin
               if (req_k < 2 * NT) begin
                  if (req_k % 2 == 0) begin
                     chk("map_addr", 48'(bus.mem_addr), 48'(e_maddr[req_k / 2]));
                     obs_maddr[req_k / 2] = int'(bus.mem_addr);
                  end else begin
                     chk("gfx_addr", 48'(bus.mem_addr), 48'(e_gaddr[req_k / 2]));
                     obs_gaddr[req_k / 2] = int'(bus.mem_addr);
                  end
               end else begin
                  chk("req_count", 48'(req_k), 48'(2 * NT - 1));
               end
               req_k++;
            end
            if (prev_req && !prev_ack && !prev_ls && !prev_rst_low)
               chk("req_hold", 48'({bus.mem_req, bus.mem_addr}), 48'({1'b1, prev_addr}));
            if (bus.tile_valid) begin
               if (ei < NT) begin
                  chk("pixels", 48'(bus.tile_pixels),     48'(e_pix[ei]));
                  chk("mask",   48'(bus.tile_valid_mask), 48'(e_mask[ei]));
                  chk("tile_x", 48'(bus.tile_x),          48'(e_tx[ei]));
                  if (bus.tile_ready) begin
                     obs_pix[ei]  = bus.tile_pixels;
                     obs_mask[ei] = bus.tile_valid_mask;
                     obs_tx[ei]   = int'(bus.tile_x);
                     ei++;
                  end
               end else begin
                  chk("word_count", 48'(ei), 48'(NT - 1));
               end
            end
            if (cyc > 2500) begin
               chk("line_timeout", 48'(cyc), 48'd2500);
               active = 1'b0;
            end
         end
         if (line_done) begin
            chk("done_words", 48'(ei), 48'(NT));
            chk("done_once",  48'(active), 48'h1);
            if (active) literal_checks();
            active = 1'b0;
         end
         if (line_start) begin
            if (active && test_id == 5) begin
               chk("abort_word",  48'(ei), 48'd7);
               chk("abort_valid", 48'(bus.tile_valid), 48'h1);
            end
            build_model();
            ei     = 0;
            req_k  = 0;
            cyc    = 0;
            active = 1'b1;
         end
         prev_rst_low = 1'b0;
      end
      prev_req  = bus.mem_req;
      prev_ack  = bus.mem_ack;
      prev_addr = bus.mem_addr;
      prev_ls   = line_start && rst_draw;
   end

   task automatic wait_idle(input int budget);
      for (int n = 0; n < budget && active; n++) @(negedge clk_draw);
   endtask

   task automatic run_line(input int tid, input logic [CORDW-1:0] y, input logic [CORDW-1:0] sx,
                           input int dly, input int stl);
      @(negedge clk_draw);
      test_id    = tid;
      ack_delay  = dly;
      stall_n    = stl;
      line_y     = y;
      scroll_x   = sx;
      line_start = 1'b1;
      @(negedge clk_draw);
      line_start = 1'b0;
      wait_idle(3000);
   endtask

   initial begin
      rst_draw   = 1'b0;
      line_start = 1'b0;
      line_y     = '0;
      scroll_x   = '0;
      map_base   = 16'h0100;
      gfx_base   = 16'h0800;
      for (int a = 0; a < 65536; a++) mem[a] = 32'(a) * 32'h9E37_79B1 ^ 32'h5A5A_5A5A;
      for (int k = 0; k < 16'h700; k++) mem[16'h100 + k] = 32'(k);
      for (int n = 0; n < 16'h400; n++) mem[16'h800 + n] = 32'(n);

      repeat (2) @(negedge clk_draw);
      line_start = 1'b1;
      @(negedge clk_draw);
      line_start = 1'b0;
      rst_draw   = 1'b1;
      repeat (2) @(negedge clk_draw);

      run_line(1, 11'h000, 11'h000, 0, 0);
      run_line(2, 11'h025, 11'h016, 0, 0);
      run_line(3, 11'h000, 11'h3F0, 0, 0);
      run_line(4, 11'h013, 11'h005, 5, 3);

      // Abort while word 7 is held by the consumer.
      @(negedge clk_draw);
      test_id    = 5;
      hold_at    = 7;
      ack_delay  = 0;
      stall_n    = 0;
      line_y     = 11'h040;
      scroll_x   = 11'h000;
      line_start = 1'b1;
      @(negedge clk_draw);
      line_start = 1'b0;
      for (int n = 0; n < 1000 && !(ei == 7 && bus.tile_valid); n++) @(negedge clk_draw);
      repeat (2) @(negedge clk_draw);
      line_y     = 11'h057;
      line_start = 1'b1;
      @(negedge clk_draw);
      line_start = 1'b0;
      hold_at    = -1;
      wait_idle(3000);

      // Reset while in GFX_REQ with a coincident ack, then a stray ack in IDLE.
      @(negedge clk_draw);
      test_id    = 6;
      ack_delay  = 100000;
      line_y     = 11'h010;
      scroll_x   = 11'h000;
      line_start = 1'b1;
      @(negedge clk_draw);
      line_start = 1'b0;
      force_ack  = 1'b1;
      @(negedge clk_draw);
      force_ack  = 1'b0;
      @(negedge clk_draw);
      rst_draw   = 1'b0;
      force_ack  = 1'b1;
      @(negedge clk_draw);
      rst_draw   = 1'b1;
      force_ack  = 1'b0;
      @(negedge clk_draw);
      force_ack  = 1'b1;
      @(negedge clk_draw);
      force_ack  = 1'b0;
      repeat (3) @(negedge clk_draw);

      run_line(7, 11'h030, 11'h020, 0, 1);

      repeat (4) @(negedge clk_draw);
      $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
      $finish;
   end
endmodule
